// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback states, and drives the datapath mux selects and write enables
// from the current state only (Moore). The one exception is pc_en, which
// folds in the ALU zero flag for beq.
module mips_mc_control #(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           iord,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsrc,
    output logic           memtoreg,
    output logic           regdst,
    output logic           irwrite,
    output logic           memwrite,
    output logic           regwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           pc_en,
    output logic           bad_op,
    output logic [SW-1:0]  state
);

    localparam logic [SW-1:0] S_FETCH   = SW'(0);
    localparam logic [SW-1:0] S_DECODE  = SW'(1);
    localparam logic [SW-1:0] S_MEMADR  = SW'(2);
    localparam logic [SW-1:0] S_MEMRD   = SW'(3);
    localparam logic [SW-1:0] S_MEMWB   = SW'(4);
    localparam logic [SW-1:0] S_MEMWR   = SW'(5);
    localparam logic [SW-1:0] S_EXECUTE = SW'(6);
    localparam logic [SW-1:0] S_ALUWB   = SW'(7);
    localparam logic [SW-1:0] S_BRANCH  = SW'(8);
    localparam logic [SW-1:0] S_ADDIEX  = SW'(9);
    localparam logic [SW-1:0] S_ADDIWB  = SW'(10);
    localparam logic [SW-1:0] S_JUMP    = SW'(11);
    localparam logic [SW-1:0] S_IDLE    = SW'(15);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    logic [SW-1:0] state_next;
    logic          bad_op_next;

    // State register plus the registered unsupported-opcode pulse; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            bad_op <= 1'b0;
        end else begin
            state  <= state_next;
            bad_op <= bad_op_next;
        end
    end

    // Next-state logic; an unknown opcode in DECODE returns to FETCH and flags bad_op.
    always_comb begin
        state_next  = S_FETCH;
        bad_op_next = 1'b0;
        case (state)
            S_IDLE:    state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next  = S_FETCH;
                        bad_op_next = 1'b1;
                    end
                endcase
            end
            // IR holds the opcode stable, so it can be re-examined here.
            S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore output decode; anything not named for a state stays 0.
    always_comb begin
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // PC load enable: unconditional writes, or a taken branch.
    assign pc_en = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed instruction runs followed by a random
// instruction stream, each cycle compared against a reference built from the
// per-instruction state sequences and the per-state control table.
module tb_mips_mc_control;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       memtoreg;
        logic       regdst;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       iord, alusrca, memtoreg, regdst;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       irwrite, memwrite, regwrite, pcwrite, branch, pc_en, bad_op;
    logic [3:0] state;
    ctl_t       obs;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_seq[8];
    int exp_len;
    bit last_bad;

    mips_mc_control #(.OPW(6), .SW(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsrc(pcsrc), .memtoreg(memtoreg), .regdst(regdst),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .pcwrite(pcwrite), .branch(branch), .pc_en(pc_en), .bad_op(bad_op),
        .state(state)
    );

    assign obs = {iord, alusrca, alusrcb, aluop, pcsrc, memtoreg, regdst,
                  irwrite, memwrite, regwrite, pcwrite, branch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word the datapath needs in each state.
    function automatic ctl_t exp_ctl(input int st);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            1:  c.alusrcb = 2'b11;
            2, 9: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            3:  c.iord = 1'b1;
            4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            10: c.regwrite = 1'b1;
            11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequence of states an instruction walks through, starting at FETCH.
    task automatic plan(input logic [5:0] op);
        exp_seq = '{default: 0};
        case (op)
            6'b100011: begin exp_seq[0:4] = '{0, 1, 2, 3, 4}; exp_len = 5; end
            6'b101011: begin exp_seq[0:3] = '{0, 1, 2, 5};    exp_len = 4; end
            6'b000000: begin exp_seq[0:3] = '{0, 1, 6, 7};    exp_len = 4; end
            6'b000100: begin exp_seq[0:2] = '{0, 1, 8};       exp_len = 3; end
            6'b001000: begin exp_seq[0:3] = '{0, 1, 9, 10};   exp_len = 4; end
            6'b000010: begin exp_seq[0:2] = '{0, 1, 11};      exp_len = 3; end
            default:   begin exp_seq[0:1] = '{0, 1};          exp_len = 2; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input int st, input bit bad_exp);
        bit pc_exp;
        pc_exp = (st == 0) || (st == 11) || ((st == 8) && zero);
        check("state", 32'(state), 32'(st));
        check("ctl", 32'(obs), 32'(exp_ctl(st)));
        check("pc_en", 32'(pc_en), 32'(pc_exp));
        check("bad_op", 32'(bad_op), 32'(bad_exp));
        check("excl", 32'($countones({memwrite, regwrite, irwrite}) <= 1), 32'd1);
    endtask

    // Run one instruction from FETCH; zmode 0/1 fixes zero, 2 randomises it.
    task automatic run_instr(input logic [5:0] op, input int zmode);
        plan(op);
        for (int i = 0; i < exp_len; i++) begin
            opcode = op;
            zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_cycle(exp_seq[i], (i == 0) && last_bad);
            @(posedge clk);
            #1;
        end
        last_bad = (exp_len == 2);
    endtask

    initial begin
        logic [5:0] ops[6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        last_bad = 1'b0;
        opcode   = 6'b0;
        zero     = 1'b0;
        rst      = 1'b1;

        // Held reset: IDLE with everything low.
        repeat (2) begin
            @(posedge clk);
            #1;
            check_cycle(15, 1'b0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed instruction mix.
        run_instr(6'b100011, 0);
        run_instr(6'b101011, 0);
        run_instr(6'b000000, 0);
        run_instr(6'b000100, 1);
        run_instr(6'b000100, 0);
        run_instr(6'b001000, 0);
        run_instr(6'b000010, 0);
        run_instr(6'b111111, 0);
        run_instr(6'b100011, 0);

        // Reset while lw sits in MEMRD: aborts before writeback.
        opcode = 6'b100011;
        zero   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_cycle(i, 1'b0);
            if (i == 3) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        check_cycle(15, 1'b0);
        check("abort_regwrite", 32'(regwrite), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        last_bad = 1'b0;

        // Random instruction stream, including arbitrary opcodes.
        for (int n = 0; n < 60; n++) begin
            int k;
            logic [5:0] op;
            k = $urandom_range(0, 6);
            if (k == 6) op = 6'($urandom_range(0, 63));
            else        op = ops[k];
            run_instr(op, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
